text_grid_engine: RTL and testbench

Parametrised, fully synchronous successor to the character display buffer. It holds a GRID_COL x GRID_ROW array of {bg colour, fg colour, ascii} cells and accepts characters and editing commands through a valid/ready handshake on clk_pix. The cursor is kept in registers and overlaid at read time, and it can blink. The block supports optional scroll-on-overflow, plus clear-screen and scroll operations that each take one cell per cycle. It sits between the keyboard/UART decoder and the VGA glyph renderer.

---
 rtl/text_grid_engine.sv | 221 ++++++++++++++++++++++
 tb/tb_text_grid_engine.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/text_grid_engine.sv
// Character cell buffer for the glyph renderer: a GRID_COL x GRID_ROW array of {bg, fg, ascii}
// cells with a blinking cursor overlay and one-cell-per-cycle clear and scroll sweeps.
module text_grid_engine #(
   parameter int GRID_COL     = 10,
   parameter int GRID_ROW     = 5,
   parameter int ASCII_WIDTH  = 8,
   parameter int COLOR_WIDTH  = 4,
   parameter int SCROLL_EN    = 1,
   parameter int CURSOR_CHAR  = 127,
   parameter int BLINK_FRAMES = 30,
   localparam int XW = $clog2(GRID_COL),
   localparam int YW = $clog2(GRID_ROW),
   localparam int W  = ASCII_WIDTH + 2*COLOR_WIDTH
) (
   input  logic                   clk_pix,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [ASCII_WIDTH-1:0] ascii,
   input  logic [COLOR_WIDTH-1:0] colorIndexF,
   input  logic [COLOR_WIDTH-1:0] colorIndexB,
   input  logic                   frame_tick,
   input  logic [XW-1:0]          rd_x,
   input  logic [YW-1:0]          rd_y,
   output logic [W-1:0]           rd_data,
   output logic [XW-1:0]          cursor_x,
   output logic [YW-1:0]          cursor_y,
   output logic                   busy
);
   localparam int N          = GRID_COL*GRID_ROW;
   localparam int AW         = $clog2(N);
   localparam int CW         = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam int BLINK_LAST = (BLINK_FRAMES > 0) ? BLINK_FRAMES-1 : 0;
   localparam int CLR_W      = 2*COLOR_WIDTH;

   localparam logic [AW-1:0] COL_A     = AW'(GRID_COL);
   localparam logic [AW-1:0] LAST_A    = AW'(N-1);
   localparam logic [AW-1:0] SHIFT_END = AW'(N-GRID_COL);
   localparam logic [XW-1:0] LAST_X    = XW'(GRID_COL-1);
   localparam logic [YW-1:0] LAST_Y    = YW'(GRID_ROW-1);

   localparam logic [ASCII_WIDTH-1:0] C_LEFT  = ASCII_WIDTH'(8'h11);
   localparam logic [ASCII_WIDTH-1:0] C_UP    = ASCII_WIDTH'(8'h12);
   localparam logic [ASCII_WIDTH-1:0] C_DOWN  = ASCII_WIDTH'(8'h13);
   localparam logic [ASCII_WIDTH-1:0] C_RIGHT = ASCII_WIDTH'(8'h14);
   localparam logic [ASCII_WIDTH-1:0] C_ENTER = ASCII_WIDTH'(8'h0D);
   localparam logic [ASCII_WIDTH-1:0] C_FF    = ASCII_WIDTH'(8'h0C);
   localparam logic [ASCII_WIDTH-1:0] C_BS    = ASCII_WIDTH'(8'h7F);

   typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_SCROLL} state_t;

   state_t           state_q, state_d;
   logic [AW-1:0]    idx_q, idx_d;
   logic [XW-1:0]    cur_x_q, cur_x_d;
   logic [YW-1:0]    cur_y_q, cur_y_d;
   logic [CLR_W-1:0] blank_q, blank_d;
   logic             vis_q, vis_d;
   logic [CW-1:0]    blink_cnt_q, blink_cnt_d;
   logic [W-1:0]     rd_data_q, rd_data_d;
   logic             in_ready_q, in_ready_d;
   logic             busy_q, busy_d;
   logic [W-1:0]     mem_q [N];

   logic             mem_we;
   logic [AW-1:0]    mem_addr, cur_a, left_a, src_a, rd_a;
   logic [W-1:0]     mem_wdata, rd_cell;
   logic [XW-1:0]    left_x;
   logic [YW-1:0]    left_y;
   logic [CLR_W-1:0] cmd_col;
   logic             rd_in;

   // Handshake: a command transfers on a rising edge where in_valid && in_ready; in_ready is
   // high only in IDLE, and ascii/colours are sampled on that same edge.
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      cur_x_d   = cur_x_q;
      cur_y_d   = cur_y_q;
      blank_d   = blank_q;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      cmd_col   = {colorIndexB, colorIndexF};
      cur_a     = AW'(cur_x_q) + COL_A * AW'(cur_y_q);
      left_a    = (cur_a == '0) ? LAST_A : cur_a - 1'b1;
      src_a     = (idx_q < SHIFT_END) ? idx_q + COL_A : idx_q;
      left_x    = (cur_x_q == '0) ? LAST_X : cur_x_q - 1'b1;
      left_y    = (cur_x_q != '0) ? cur_y_q : ((cur_y_q == '0) ? LAST_Y : cur_y_q - 1'b1);
      case (state_q)
         S_IDLE: begin
            if (in_valid && in_ready_q) begin
               case (ascii)
                  C_LEFT: begin
                     cur_x_d = left_x;
                     cur_y_d = left_y;
                  end
                  C_RIGHT: begin
                     if (cur_x_q != LAST_X) cur_x_d = cur_x_q + 1'b1;
                     else begin
                        cur_x_d = '0;
                        cur_y_d = (cur_y_q == LAST_Y) ? '0 : cur_y_q + 1'b1;
                     end
                  end
                  C_UP: cur_y_d = (cur_y_q == '0) ? LAST_Y : cur_y_q - 1'b1;
                  C_DOWN, C_ENTER: begin
                     if (ascii == C_ENTER) cur_x_d = '0;
                     if (cur_y_q != LAST_Y) cur_y_d = cur_y_q + 1'b1;
                     else if (SCROLL_EN != 0) begin
                        state_d = S_SCROLL;
                        idx_d   = '0;
                        blank_d = cmd_col;
                     end else cur_y_d = '0;
                  end
                  C_BS: begin
                     cur_x_d   = left_x;
                     cur_y_d   = left_y;
                     mem_we    = 1'b1;
                     mem_addr  = left_a;
                     mem_wdata = {cmd_col, {ASCII_WIDTH{1'b0}}};
                  end
                  C_FF: begin
                     state_d = S_CLEAR;
                     idx_d   = '0;
                     cur_x_d = '0;
                     cur_y_d = '0;
                     blank_d = cmd_col;
                  end
                  default: begin
                     mem_we    = 1'b1;
                     mem_addr  = cur_a;
                     mem_wdata = {cmd_col, ascii};
                     if (cur_x_q != LAST_X) cur_x_d = cur_x_q + 1'b1;
                     else begin
                        cur_x_d = '0;
                        if (cur_y_q != LAST_Y) cur_y_d = cur_y_q + 1'b1;
                        else if (SCROLL_EN != 0) begin
                           state_d = S_SCROLL;
                           idx_d   = '0;
                           blank_d = cmd_col;
                        end else cur_y_d = '0;
                     end
                  end
               endcase
            end
         end
         S_CLEAR, S_SCROLL: begin
            mem_we    = 1'b1;
            mem_addr  = idx_q;
            mem_wdata = {blank_q, {ASCII_WIDTH{1'b0}}};
            if (state_q == S_SCROLL && idx_q < SHIFT_END) mem_wdata = mem_q[src_a];
            if (idx_q == LAST_A) begin
               state_d = S_IDLE;
               idx_d   = '0;
            end else idx_d = idx_q + 1'b1;
         end
         default: state_d = S_CLEAR;
      endcase
      in_ready_d = (state_d == S_IDLE);
      busy_d     = (state_d != S_IDLE);
   end

   always_comb begin
      vis_d       = vis_q;
      blink_cnt_d = blink_cnt_q;
      if (BLINK_FRAMES != 0 && frame_tick) begin
         if (blink_cnt_q == CW'(BLINK_LAST)) begin
            blink_cnt_d = '0;
            vis_d       = ~vis_q;
         end else blink_cnt_d = blink_cnt_q + 1'b1;
      end
   end

   // The cursor glyph is overlaid only while idle so sweeps show raw contents.
   always_comb begin
      rd_in     = (int'(rd_x) < GRID_COL) && (int'(rd_y) < GRID_ROW);
      rd_a      = rd_in ? AW'(rd_x) + COL_A * AW'(rd_y) : '0;
      rd_cell   = mem_q[rd_a];
      rd_data_d = '0;
      if (rd_in) begin
         rd_data_d = rd_cell;
         if (rd_x == cur_x_q && rd_y == cur_y_q && vis_q && state_q == S_IDLE)
            rd_data_d[ASCII_WIDTH-1:0] = ASCII_WIDTH'(CURSOR_CHAR);
      end
   end

   always_ff @(posedge clk_pix or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_CLEAR;
         idx_q       <= '0;
         cur_x_q     <= '0;
         cur_y_q     <= '0;
         blank_q     <= '0;
         vis_q       <= 1'b1;
         blink_cnt_q <= '0;
         rd_data_q   <= '0;
         in_ready_q  <= 1'b0;
         busy_q      <= 1'b1;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         cur_x_q     <= cur_x_d;
         cur_y_q     <= cur_y_d;
         blank_q     <= blank_d;
         vis_q       <= vis_d;
         blink_cnt_q <= blink_cnt_d;
         rd_data_q   <= rd_data_d;
         in_ready_q  <= in_ready_d;
         busy_q      <= busy_d;
      end
   end

   always_ff @(posedge clk_pix) begin
      if (mem_we) mem_q[mem_addr] <= mem_wdata;
   end

   assign in_ready = in_ready_q;
   assign busy     = busy_q;
   assign rd_data  = rd_data_q;
   assign cursor_x = cur_x_q;
   assign cursor_y = cur_y_q;
endmodule

// File: tb/tb_text_grid_engine.sv
// Directed bench for text_grid_engine: unit 0 scrolls and blinks every 2 frames,
// unit 1 wraps instead of scrolling and keeps the cursor always visible.
module tb_text_grid_engine;
   typedef struct {
      int         u;
      bit         rd;
      logic [7:0] code;
      logic [3:0] f;
      logic [3:0] b;
      logic [3:0] x;
      logic [2:0] y;
      logic [15:0] exp;
   } vec_t;

   logic        clk_pix;
   logic        rst_n;
   logic        in_valid [2];
   logic        in_ready [2];
   logic [7:0]  ascii [2];
   logic [3:0]  col_f [2];
   logic [3:0]  col_b [2];
   logic        frame_tick [2];
   logic [3:0]  rd_x [2];
   logic [2:0]  rd_y [2];
   logic [15:0] rd_data [2];
   logic [3:0]  cursor_x [2];
   logic [2:0]  cursor_y [2];
   logic        busy [2];

   int total = 0;
   int bad   = 0;
   logic arm1 = 1'b0;
   logic busy1_seen;
   vec_t tbl [$];

   text_grid_engine #(.SCROLL_EN(1), .BLINK_FRAMES(2)) u_scroll (
      .clk_pix(clk_pix), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
      .ascii(ascii[0]), .colorIndexF(col_f[0]), .colorIndexB(col_b[0]),
      .frame_tick(frame_tick[0]), .rd_x(rd_x[0]), .rd_y(rd_y[0]), .rd_data(rd_data[0]),
      .cursor_x(cursor_x[0]), .cursor_y(cursor_y[0]), .busy(busy[0]));

   text_grid_engine #(.SCROLL_EN(0), .BLINK_FRAMES(0)) u_wrap (
      .clk_pix(clk_pix), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
      .ascii(ascii[1]), .colorIndexF(col_f[1]), .colorIndexB(col_b[1]),
      .frame_tick(frame_tick[1]), .rd_x(rd_x[1]), .rd_y(rd_y[1]), .rd_data(rd_data[1]),
      .cursor_x(cursor_x[1]), .cursor_y(cursor_y[1]), .busy(busy[1]));

   initial clk_pix = 1'b0;
   always #5 clk_pix = ~clk_pix;

   always @(negedge clk_pix) begin
      if (!rst_n) busy1_seen <= 1'b0;
      else if (arm1 && busy[1]) busy1_seen <= 1'b1;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic send(input int u, input logic [7:0] c, input logic [3:0] f,
                       input logic [3:0] b, output int n);
      n = 0;
      @(negedge clk_pix);
      in_valid[u] = 1'b1; ascii[u] = c; col_f[u] = f; col_b[u] = b;
      while (!in_ready[u] && n < 200) begin
         @(negedge clk_pix);
         n++;
      end
      if (!in_ready[u]) check($sformatf("accept_timeout_u%0d", u), 32'd0, 32'd1);
      @(negedge clk_pix);
      in_valid[u] = 1'b0;
   endtask

   task automatic read_cell(input int u, input logic [3:0] x, input logic [2:0] y,
                            output logic [15:0] d);
      @(negedge clk_pix);
      rd_x[u] = x; rd_y[u] = y;
      @(negedge clk_pix);
      d = rd_data[u];
   endtask

   task automatic check_cursor(input string name, input int u, input logic [3:0] ex,
                               input logic [2:0] ey);
      check(name, {cursor_x[u], cursor_y[u]}, {ex, ey});
   endtask

   task automatic pulse_tick(input int u);
      @(negedge clk_pix);
      frame_tick[u] = 1'b1;
      @(negedge clk_pix);
      frame_tick[u] = 1'b0;
   endtask

   function automatic vec_t vs(input int u, input logic [7:0] c, input logic [3:0] f,
                               input logic [3:0] b, input logic [3:0] ex, input logic [2:0] ey);
      vec_t v;
      v = '{u: u, rd: 1'b0, code: c, f: f, b: b, x: ex, y: ey, exp: 16'h0};
      return v;
   endfunction

   function automatic vec_t vr(input int u, input logic [3:0] x, input logic [2:0] y,
                               input logic [15:0] e);
      vec_t v;
      v = '{u: u, rd: 1'b1, code: 8'h0, f: 4'h0, b: 4'h0, x: x, y: y, exp: e};
      return v;
   endfunction

   initial begin
      int n;
      logic [15:0] d;
      logic [15:0] e;
      rst_n = 1'b0;
      for (int u = 0; u < 2; u++) begin
         in_valid[u] = 1'b0; ascii[u] = '0; col_f[u] = '0; col_b[u] = '0;
         frame_tick[u] = 1'b0; rd_x[u] = '0; rd_y[u] = '0;
      end
      repeat (3) @(negedge clk_pix);
      check("reset_in_ready", in_ready[0], 1'b0);
      check("reset_busy", busy[0], 1'b1);
      check("reset_rd_data", rd_data[0], 16'h0);
      check_cursor("reset_cursor", 0, 4'd0, 3'd0);

      rst_n = 1'b1;
      n = 0;
      while (!in_ready[0] && n < 200) begin
         @(negedge clk_pix);
         n++;
      end
      check("reset_clear_cycles", n, 50);
      check("reset_busy_done", busy[0], 1'b0);
      check("reset_u1_ready", in_ready[1], 1'b1);
      arm1 = 1'b1;

      for (int i = 0; i < 50; i++) begin
         read_cell(0, 4'(i % 10), 3'(i / 10), d);
         check($sformatf("reset_cell_%0d", i), d, (i == 0) ? 16'h007F : 16'h0000);
      end

      tbl.push_back(vs(0, 8'h41, 4'd3, 4'd5, 4'd1, 3'd0));
      tbl.push_back(vr(0, 4'd0, 3'd0, 16'h5341));
      tbl.push_back(vr(0, 4'd1, 3'd0, 16'h007F));
      tbl.push_back(vs(0, 8'h11, 4'd0, 4'd0, 4'd0, 3'd0));
      tbl.push_back(vr(0, 4'd0, 3'd0, 16'h537F));
      tbl.push_back(vs(0, 8'h11, 4'd0, 4'd0, 4'd9, 3'd4));
      tbl.push_back(vr(0, 4'd9, 3'd4, 16'h007F));
      tbl.push_back(vs(0, 8'h14, 4'd0, 4'd0, 4'd0, 3'd0));
      tbl.push_back(vs(0, 8'h12, 4'd0, 4'd0, 4'd0, 3'd4));
      tbl.push_back(vs(0, 8'h12, 4'd0, 4'd0, 4'd0, 3'd3));
      tbl.push_back(vs(0, 8'h13, 4'd0, 4'd0, 4'd0, 3'd4));
      tbl.push_back(vs(0, 8'h14, 4'd0, 4'd0, 4'd1, 3'd4));
      tbl.push_back(vs(0, 8'h11, 4'd0, 4'd0, 4'd0, 3'd4));
      tbl.push_back(vs(0, 8'h11, 4'd0, 4'd0, 4'd9, 3'd3));
      tbl.push_back(vs(0, 8'h14, 4'd0, 4'd0, 4'd0, 3'd4));
      tbl.push_back(vs(0, 8'h0C, 4'd0, 4'd0, 4'd0, 3'd0));
      tbl.push_back(vs(0, 8'h7F, 4'd6, 4'd7, 4'd9, 3'd4));
      tbl.push_back(vr(0, 4'd9, 3'd4, 16'h767F));
      tbl.push_back(vr(0, 4'd8, 3'd4, 16'h0000));
      tbl.push_back(vr(0, 4'd0, 3'd0, 16'h0000));
      tbl.push_back(vs(0, 8'h14, 4'd0, 4'd0, 4'd0, 3'd0));
      tbl.push_back(vr(0, 4'd9, 3'd4, 16'h7600));
      tbl.push_back(vr(0, 4'd10, 3'd0, 16'h0000));
      tbl.push_back(vr(0, 4'd0, 3'd5, 16'h0000));
      tbl.push_back(vr(0, 4'd0, 3'd0, 16'h007F));
      tbl.push_back(vs(1, 8'h11, 4'd0, 4'd0, 4'd9, 3'd4));
      tbl.push_back(vs(1, 8'h5A, 4'd3, 4'd1, 4'd0, 3'd0));
      tbl.push_back(vr(1, 4'd9, 3'd4, 16'h135A));
      tbl.push_back(vs(1, 8'h12, 4'd0, 4'd0, 4'd0, 3'd4));
      tbl.push_back(vs(1, 8'h0D, 4'd0, 4'd0, 4'd0, 3'd0));
      tbl.push_back(vs(1, 8'h12, 4'd0, 4'd0, 4'd0, 3'd4));
      tbl.push_back(vs(1, 8'h13, 4'd0, 4'd0, 4'd0, 3'd0));
      tbl.push_back(vs(1, 8'h7F, 4'd0, 4'd0, 4'd9, 3'd4));
      tbl.push_back(vr(1, 4'd9, 3'd4, 16'h007F));
      tbl.push_back(vs(1, 8'h14, 4'd0, 4'd0, 4'd0, 3'd0));
      tbl.push_back(vr(1, 4'd9, 3'd4, 16'h0000));

      foreach (tbl[i]) begin
         if (tbl[i].rd) begin
            read_cell(tbl[i].u, tbl[i].x, tbl[i].y, d);
            check($sformatf("vec%0d_rd_u%0d", i, tbl[i].u), d, tbl[i].exp);
         end else begin
            send(tbl[i].u, tbl[i].code, tbl[i].f, tbl[i].b, n);
            check_cursor($sformatf("vec%0d_cursor_u%0d", i, tbl[i].u), tbl[i].u,
                         tbl[i].x, tbl[i].y);
         end
      end
      check("wrap_never_busy", busy1_seen, 1'b0);

      // Form feed on unit 1 with a command held valid through the sweep.
      send(1, 8'h0C, 4'd2, 4'd1, n);
      check_cursor("ff_cursor", 1, 4'd0, 3'd0);
      send(1, 8'h51, 4'd5, 4'd6, n);
      check("held_valid_wait", n, 49);
      check_cursor("held_valid_cursor", 1, 4'd1, 3'd0);
      for (int i = 0; i < 50; i++) begin
         e = (i == 0) ? 16'h6551 : ((i == 1) ? 16'h127F : 16'h1200);
         read_cell(1, 4'(i % 10), 3'(i / 10), d);
         check($sformatf("ff_cell_%0d", i), d, e);
      end

      // Fill rows 0-1 on unit 0, then overflow with enter to force a scroll.
      for (int i = 0; i < 20; i++) begin
         send(0, 8'(8'h61 + i), 4'd1, 4'd2, n);
         if (i == 9) check_cursor("fill_row0_cursor", 0, 4'd0, 3'd1);
      end
      check_cursor("fill_cursor", 0, 4'd0, 3'd2);
      send(0, 8'h0D, 4'd0, 4'd0, n);
      send(0, 8'h0D, 4'd0, 4'd0, n);
      check_cursor("enter_cursor", 0, 4'd0, 3'd4);
      send(0, 8'h0D, 4'd4, 4'd8, n);
      n = 0;
      while (busy[0] && n < 200) begin
         @(negedge clk_pix);
         n++;
      end
      check("scroll_cycles", n, 50);
      check_cursor("scroll_cursor", 0, 4'd0, 3'd4);
      for (int x = 0; x < 10; x++) begin
         read_cell(0, 4'(x), 3'd0, d);
         check($sformatf("scroll_row0_%0d", x), d, 16'h2100 | 16'(8'h6B + x));
         read_cell(0, 4'(x), 3'd1, d);
         check($sformatf("scroll_row1_%0d", x), d, 16'h0000);
         read_cell(0, 4'(x), 3'd4, d);
         check($sformatf("scroll_row4_%0d", x), d, (x == 0) ? 16'h847F : 16'h8400);
      end
      read_cell(0, 4'd9, 3'd3, d);
      check("scroll_row3_moved", d, 16'h7600);

      pulse_tick(0);
      read_cell(0, 4'd0, 3'd4, d);
      check("blink_1tick_visible", d, 16'h847F);
      pulse_tick(0);
      read_cell(0, 4'd0, 3'd4, d);
      check("blink_hidden", d, 16'h8400);
      pulse_tick(0);
      pulse_tick(0);
      read_cell(0, 4'd0, 3'd4, d);
      check("blink_visible_again", d, 16'h847F);

      send(0, 8'h0C, 4'd9, 4'd10, n);
      read_cell(0, 4'd0, 3'd0, d);
      check("clear_no_overlay", d, 16'hA900);
      n = 0;
      while (busy[0] && n < 200) begin
         @(negedge clk_pix);
         n++;
      end
      check("final_idle", busy[0], 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
